// File: rtl/alu_input_fsm_if.sv
// alu_input_fsm_if: bundles the operator-facing inputs (abort, button, switches)
// and the load-enable/data bus that the sequencer drives toward the ALU registers.
// The master side is whoever drives the switches and button. The slave side is
// the sequencer itself.
interface alu_input_fsm_if #(
   parameter int N   = 4,
   parameter int OPW = 4
);
   logic           clr;
   logic           btn;
   logic [N-1:0]   sw;
   logic [N-1:0]   ld_data;
   logic [OPW-1:0] ld_op;
   logic           en_a;
   logic           en_b;
   logic           en_op;
   logic           en_res;
   logic [2:0]     state;
   logic           done;

   modport master (
      output clr, btn, sw,
      input  ld_data, ld_op, en_a, en_b, en_op, en_res, state, done
   );

   modport slave (
      input  clr, btn, sw,
      output ld_data, ld_op, en_a, en_b, en_op, en_res, state, done
   );
endinterface

// File: rtl/alu_input_fsm.sv
// alu_input_fsm: debounces one push-button and walks the operator through
// loading operand A, operand B and the opcode, then strobes the result register.
// Each step produces a one-cycle load enable together with a registered copy of
// the switch bank. done stays high while a result is on display.
module alu_input_fsm #(
   parameter int N               = 4,
   parameter int OPW             = 4,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input logic              clk,
   input logic              rst,
   alu_input_fsm_if.slave   bus
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_SHOW = 3'd4
   } state_t;

   logic          r_sync1;
   logic          r_sync2;
   logic [1:0]    r_fill;
   logic          r_stable;
   logic [CW-1:0] r_cnt;
   logic          r_press;
   logic          r_armed;

   state_t        r_state;
   logic [N-1:0]  r_ld_data;
   logic          r_en_a;
   logic          r_en_b;
   logic          r_en_op;
   logic          r_en_res;
   logic          r_done;

   logic          w_sync;
   logic          w_syncValid;

   assign w_sync      = r_sync2;
   assign w_syncValid = r_fill[1];

   // Two-flop synchronizer for the raw button. r_fill marks when both flops hold
   // real samples again after a reset, so the cleared flops are not mistaken for
   // a released button.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_fill  <= 2'b00;
      end else begin
         r_sync1 <= bus.btn;
         r_sync2 <= r_sync1;
         r_fill  <= {r_fill[0], 1'b1};
      end
   end

   // Debouncer: the stable level flips only after DEBOUNCE_CYCLES consecutive
   // disagreeing samples, and a press is a registered pulse on a stable 0->1 flip.
   // r_armed is set only after a genuine low level has been seen, so a button
   // held through reset does not count as a press until it is released.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stable <= 1'b0;
         r_cnt    <= '0;
         r_press  <= 1'b0;
         r_armed  <= 1'b0;
      end else begin
         r_press <= 1'b0;
         if (w_syncValid && !w_sync) begin
            r_armed <= 1'b1;
         end
         if (w_sync != r_stable) begin
            if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               r_stable <= w_sync;
               r_cnt    <= '0;
               r_press  <= w_sync & r_armed;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   // Sequencer: advances on each press and issues exactly one enable per step.
   // Abort takes priority over a press on the same edge, and the unused state
   // codes fall back to operand-A entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_A;
         r_ld_data <= '0;
         r_en_a    <= 1'b0;
         r_en_b    <= 1'b0;
         r_en_op   <= 1'b0;
         r_en_res  <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_en_a   <= 1'b0;
         r_en_b   <= 1'b0;
         r_en_op  <= 1'b0;
         r_en_res <= 1'b0;
         if (bus.clr) begin
            r_state <= S_A;
            r_done  <= 1'b0;
         end else begin
            case (r_state)
               S_A: begin
                  if (r_press) begin
                     r_state   <= S_B;
                     r_en_a    <= 1'b1;
                     r_ld_data <= bus.sw;
                  end
               end
               S_B: begin
                  if (r_press) begin
                     r_state   <= S_OP;
                     r_en_b    <= 1'b1;
                     r_ld_data <= bus.sw;
                  end
               end
               S_OP: begin
                  if (r_press) begin
                     r_state   <= S_EXEC;
                     r_en_op   <= 1'b1;
                     r_ld_data <= bus.sw;
                  end
               end
               S_EXEC: begin
                  r_state  <= S_SHOW;
                  r_en_res <= 1'b1;
                  r_done   <= 1'b1;
               end
               S_SHOW: begin
                  if (r_press) begin
                     r_state <= S_A;
                     r_done  <= 1'b0;
                  end
               end
               default: begin
                  r_state <= S_A;
                  r_done  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.ld_data = r_ld_data;
   assign bus.ld_op   = r_ld_data[OPW-1:0];
   assign bus.en_a    = r_en_a;
   assign bus.en_b    = r_en_b;
   assign bus.en_op   = r_en_op;
   assign bus.en_res  = r_en_res;
   assign bus.state   = r_state;
   assign bus.done    = r_done;

endmodule

// File: tb/tb_alu_input_fsm.sv
// tb_alu_input_fsm: directed bench for the operand-entry sequencer with a short
// debounce window. A table drives the main A/B/opcode/show walk. Hand-written
// sequences cover reset with the button held, bounce, glitch, hold, abort and a
// reset in the middle of a sequence.
module tb_alu_input_fsm;

   localparam int N   = 4;
   localparam int OPW = 4;
   localparam int DB  = 4;
   localparam int LAT = DB + 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   alu_input_fsm_if #(.N(N), .OPW(OPW)) bus ();

   alu_input_fsm #(.N(N), .OPW(OPW), .DEBOUNCE_CYCLES(DB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int nChecks = 0;
   int nFails  = 0;

   typedef struct {
      logic [N-1:0] sw;
      logic [3:0]   expEn;
      int           expLat;
      logic [2:0]   expState;
      logic [N-1:0] expLd;
      logic         expDone;
   } vec_t;

   vec_t vecs[4];

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      nChecks++;
      if (actual != expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic logic [3:0] enVec();
      return {bus.en_res, bus.en_op, bus.en_b, bus.en_a};
   endfunction

   // Raise the button with the given switches and watch LAT edges for enables.
   task automatic applyStimulus(input logic [N-1:0] swVal, output int firstEn,
                                output logic [3:0] enAtLat, output int enCount);
      bus.sw  = swVal;
      bus.btn = 1'b1;
      firstEn = -1;
      enCount = 0;
      enAtLat = 4'b0000;
      for (int e = 1; e <= LAT; e++) begin
         tick();
         if (enVec() != 4'b0000) begin
            enCount++;
            if (firstEn < 0) firstEn = e;
         end
         if (e == LAT) enAtLat = enVec();
      end
   endtask

   task automatic releaseBtn();
      bus.btn = 1'b0;
      repeat (10) tick();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int         firstEn;
      logic [3:0] enAtLat;
      int         enCount;
      int         extra;
      int         badState;

      vecs[0] = '{4'd3, 4'b0001, LAT, 3'd1, 4'd3, 1'b0};
      vecs[1] = '{4'd5, 4'b0010, LAT, 3'd2, 4'd5, 1'b0};
      vecs[2] = '{4'd2, 4'b0100, LAT, 3'd3, 4'd2, 1'b0};
      vecs[3] = '{4'd9, 4'b0000, -1,  3'd0, 4'd2, 1'b0};

      // Reset with the button held down and all switches up.
      rst     = 1'b1;
      bus.clr = 1'b0;
      bus.btn = 1'b1;
      bus.sw  = 4'hF;
      tick();
      tick();
      checkOutput("reset_state", bus.state, 0);
      checkOutput("reset_en", enVec(), 0);
      checkOutput("reset_ld", bus.ld_data, 0);
      checkOutput("reset_done", bus.done, 0);
      rst = 1'b0;
      extra = 0;
      repeat (20) begin
         tick();
         if (enVec() != 4'b0000) extra++;
      end
      checkOutput("held_after_reset_en", extra, 0);
      checkOutput("held_after_reset_state", bus.state, 0);
      releaseBtn();

      // Main walk through the table.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(vecs[i].sw, firstEn, enAtLat, enCount);
         checkOutput($sformatf("vec%0d_latency", i), firstEn, vecs[i].expLat);
         checkOutput($sformatf("vec%0d_en", i), enAtLat, vecs[i].expEn);
         checkOutput($sformatf("vec%0d_state", i), bus.state, vecs[i].expState);
         checkOutput($sformatf("vec%0d_ld", i), bus.ld_data, vecs[i].expLd);
         checkOutput($sformatf("vec%0d_done", i), bus.done, vecs[i].expDone);
         if (vecs[i].expEn == 4'b0100) begin
            tick();
            checkOutput("exec_en_res", enVec(), 4'b1000);
            checkOutput("exec_state", bus.state, 4);
            checkOutput("exec_done", bus.done, 1);
            checkOutput("exec_ld", bus.ld_data, 2);
            checkOutput("exec_ld_op", bus.ld_op, 2);
         end
         releaseBtn();
      end

      // Bouncing button followed by a steady press.
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         bus.btn = (i % 2 == 0);
         repeat (2) begin
            tick();
            if (enVec() != 4'b0000) extra++;
         end
      end
      checkOutput("bounce_no_en", extra, 0);
      applyStimulus(4'd6, firstEn, enAtLat, enCount);
      checkOutput("bounce_latency", firstEn, LAT);
      checkOutput("bounce_en", enAtLat, 4'b0001);
      checkOutput("bounce_count", enCount, 1);
      checkOutput("bounce_ld", bus.ld_data, 6);
      releaseBtn();
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      checkOutput("clr_state", bus.state, 0);

      // Short glitch shorter than the debounce window.
      bus.btn = 1'b1;
      repeat (3) tick();
      bus.btn = 1'b0;
      extra = 0;
      repeat (10) begin
         tick();
         if (enVec() != 4'b0000) extra++;
      end
      checkOutput("glitch_no_en", extra, 0);
      checkOutput("glitch_state", bus.state, 0);
      checkOutput("glitch_cnt", dut.r_cnt, 0);

      // Button held for 100 cycles in operand-A entry.
      applyStimulus(4'd1, firstEn, enAtLat, enCount);
      checkOutput("hold_latency", firstEn, LAT);
      checkOutput("hold_en", enAtLat, 4'b0001);
      extra = 0;
      badState = 0;
      repeat (100 - LAT) begin
         tick();
         if (enVec() != 4'b0000) extra++;
         if (bus.state != 3'd1) badState++;
      end
      checkOutput("hold_extra_en", extra, 0);
      checkOutput("hold_state_bad", badState, 0);
      releaseBtn();

      // Load B, then abort the opcode press on the very edge it would load.
      applyStimulus(4'd5, firstEn, enAtLat, enCount);
      checkOutput("abort_prep_en", enAtLat, 4'b0010);
      checkOutput("abort_prep_state", bus.state, 2);
      releaseBtn();
      bus.sw  = 4'd2;
      bus.btn = 1'b1;
      extra = 0;
      repeat (LAT - 1) begin
         tick();
         if (enVec() != 4'b0000) extra++;
      end
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      if (enVec() != 4'b0000) extra++;
      checkOutput("abort_no_en", extra, 0);
      checkOutput("abort_state", bus.state, 0);
      checkOutput("abort_ld", bus.ld_data, 5);
      checkOutput("abort_done", bus.done, 0);
      extra = 0;
      repeat (10) begin
         tick();
         if (enVec() != 4'b0000) extra++;
      end
      checkOutput("abort_held_no_en", extra, 0);
      checkOutput("abort_held_state", bus.state, 0);
      releaseBtn();
      applyStimulus(4'd7, firstEn, enAtLat, enCount);
      checkOutput("repress_latency", firstEn, LAT);
      checkOutput("repress_ld", bus.ld_data, 7);
      checkOutput("repress_state", bus.state, 1);
      releaseBtn();

      // Reset after A is loaded throws away progress.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("midrst_state", bus.state, 0);
      checkOutput("midrst_ld", bus.ld_data, 0);
      repeat (5) tick();
      applyStimulus(4'd8, firstEn, enAtLat, enCount);
      checkOutput("midrst_en", enAtLat, 4'b0001);
      checkOutput("midrst_reload_ld", bus.ld_data, 8);
      checkOutput("midrst_reload_state", bus.state, 1);
      releaseBtn();

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/alu_input_fsm.md
# alu_input_fsm

Operand-entry sequencer upstream of the ALU operand/result registers. Takes a single switch bank and one raw push-button, debounces the button, and steps through loading operand A, operand B and the opcode. It then captures the result. For each step it drives a one-cycle load-enable plus a registered data bus to the matching N-bit enable register. A flag tells the display logic when a result is held.

## Interface

- N, 4, operand width (switch bits used for A and B)
- OPW, 4, opcode width (low OPW switch bits used in the opcode step; OPW ≤ N)
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a button level change (≥ 2)

- clk  in  1  system clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- clr  in  1  synchronous abort, already clean; returns to operand-A entry
- btn  in  1  raw push-button, active-high, asynchronous and bouncy
- sw  in  N  switch bank, sampled only on an accepted press
- ld_data  out  N  registered copy of sw, valid while any en_* is high
- en_a  out  1  one-cycle load enable for operand-A register
- en_b  out  1  one-cycle load enable for operand-B register
- en_op  out  1  one-cycle load enable for opcode register (consumes ld_data[OPW-1:0])
- en_res  out  1  one-cycle load enable for result/flags register
- state  out  3  current state code
- done  out  1  high while a result is held (S_SHOW)

## Operation

- Input path:
  - btn goes through a 2-flop synchronizer, then a debouncer.
  - The debouncer has a counter of width clog2(DEBOUNCE_CYCLES)+1. It increments while the synced level differs from the stable level, and clears when they are equal.
  - When the count reaches DEBOUNCE_CYCLES, the stable level toggles and the counter clears.
  - press is a one-cycle internal pulse on a stable 0→1 transition only.
  - A release never produces a press. A held button produces exactly one press.
- States (code): S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4. Codes 5–7 are unreachable and recover to S_A on the next edge.
- S_A + press → S_B. On the same edge: en_a=1, ld_data=sw.
- S_B + press → S_OP. On the same edge: en_b=1, ld_data=sw.
- S_OP + press → S_EXEC. On the same edge: en_op=1, ld_data=sw.
- S_EXEC → S_SHOW unconditionally after one cycle. On that edge: en_res=1, ld_data unchanged. The ALU result register captures on this pulse.
- S_SHOW: done=1. A press → S_A, with no enable asserted.
- All outputs are registered. Every en_* is high for exactly one cycle, and at most one en_* is high in any cycle.
- ld_data holds its last value when no enable is active.
- sw changes outside the sampling edge have no effect.

## Timing

- rst (highest priority) and clr (next): on the edge where either is high:
  - state=S_A, all en_*=0, done=0.
  - rst additionally clears ld_data=0, the synchronizer flops, the stable level and the debounce counter.
  - clr leaves the debouncer running.
- clr and press on the same edge: clr wins and the press is discarded. A button still held after clr generates no further press until it is released and pressed again.
- press→enable latency: en_x rises exactly DEBOUNCE_CYCLES+3 edges after the first edge that samples btn=1, given btn is held steady.
- A glitch shorter than DEBOUNCE_CYCLES synced cycles never toggles the stable level; the counter restarts at 0.
- S_OP press → en_op at edge k, then en_res at edge k+1, then done=1 from edge k+1.
- rst mid-sequence, e.g. after A is loaded, discards progress. The next press loads A again.

## Test plan

Run with DEBOUNCE_CYCLES=4, N=4, OPW=4.

- Reset: assert rst for 2 cycles, with btn=1 and sw=4'hF → state=0, all en_*=0, ld_data=0, done=0. After release, no press until btn goes low and is pressed again.
- Full sequence:
  - sw=3, clean press → en_a pulse, ld_data=3, 7 edges after btn rise.
  - sw=5 press → en_b, ld_data=5.
  - sw=2 press → en_op, ld_data=2; en_res next cycle; state=4, done=1.
  - Another press → state=0, done=0, no en_*.
- Bounce: btn toggles high/low every 2 cycles for 20 cycles, then stays high → exactly one en_a pulse, timed from the final steady high edge.
- Short glitch: btn high for 3 cycles, then low → no enable, state unchanged, counter back to 0.
- Hold: btn held high for 100 cycles in S_A → one en_a only; state=1 throughout.
- Abort: in S_OP, clr asserted on the same edge as press → no en_op, state=0, ld_data keeps the B value (5).
